// File: rtl/tlp_rx_align.sv
// tlp_rx_align: pulls the 3DW/4DW header off inbound memory-write TLPs on a
// 256-bit PCIe RX stream and realigns the payload so payload DW0 lands at
// tlp_data[255:224]. Non-MWr TLPs are dropped and counted.
module tlp_rx_align #(
    parameter int DW         = 32,
    parameter int DATA_WIDTH = 256,
    parameter int HDR_WIDTH  = 128,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_sop,
    input  logic                  rx_eop,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [HDR_WIDTH-1:0]  tlp_hdr,
    output logic [DATA_WIDTH-1:0] tlp_data,
    output logic [3:0]            tlp_dw_cnt,
    output logic                  tlp_sop,
    output logic                  tlp_eop,
    output logic                  tlp_valid,
    input  logic                  tlp_ready,
    output logic                  rx_err,
    output logic [CNT_WIDTH-1:0]  drop_cnt
);
    localparam int NDW = DATA_WIDTH / DW;
    localparam int LW  = 11;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BODY  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DROP  = 2'd3;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [3:0]            cnt;
        logic                  sop;
        logic                  eop;
    } beat_t;

    logic [1:0]            state, state_nx;
    logic [LW-1:0]         rem, rem_nx;
    logic [DATA_WIDTH-1:0] tail, tail_nx;
    logic                  hdr4, hdr4_nx;
    logic                  first, first_nx;
    logic                  run;

    logic                  out_free, acc;
    logic                  in_4dw, in_mwr;
    logic [9:0]            in_len10;
    logic [LW-1:0]         in_len, in_tcnt, cur_tcnt;
    logic [DATA_WIDTH-1:0] in_tail, body_data, cur_tail_nx;
    logic [HDR_WIDTH-1:0]  in_hdr;
    logic [3:0]            body_cnt;
    logic [LW-1:0]         rem_after;

    logic                  emit, err_nx, drop_inc, hdr_ld;
    beat_t                 e_beat;
    logic [DATA_WIDTH-1:0] emit_mask;

    // Input side is stalled while the output register is full or the tail is being flushed.
    // run keeps rx_ready low through reset and until the first clock after it.
    assign out_free = !tlp_valid || tlp_ready;
    assign rx_ready = run && out_free && (state != S_FLUSH);
    assign acc      = rx_valid && rx_ready;

    // Header decode of the incoming beat: fmt[0] selects 4DW, MWr is fmt[1]=1 with type 0.
    assign in_4dw   = rx_data[DATA_WIDTH-3];
    assign in_mwr   = rx_data[DATA_WIDTH-2] && (rx_data[DATA_WIDTH-4 -: 5] == 5'd0);
    assign in_len10 = rx_data[DATA_WIDTH-DW +: 10];
    assign in_len   = {(in_len10 == 10'd0), in_len10};
    assign in_tcnt  = in_4dw ? LW'(NDW-4) : LW'(NDW-3);
    assign cur_tcnt = hdr4   ? LW'(NDW-4) : LW'(NDW-3);
    assign in_hdr   = {rx_data[DATA_WIDTH-1 -: HDR_WIDTH-DW],
                       in_4dw ? rx_data[DATA_WIDTH-HDR_WIDTH +: DW] : {DW{1'b0}}};

    // Tail = DWs H..7 of a beat, left-aligned. A body beat joins the held tail with
    // the first H DWs of the new beat, dropped in just below it.
    assign in_tail     = in_4dw ? (rx_data << (4*DW)) : (rx_data << (3*DW));
    assign cur_tail_nx = hdr4   ? (rx_data << (4*DW)) : (rx_data << (3*DW));
    assign body_data   = tail | (hdr4 ? (rx_data >> ((NDW-4)*DW)) : (rx_data >> ((NDW-3)*DW)));
    assign body_cnt    = (rem >= LW'(NDW)) ? 4'(NDW) : rem[3:0];
    assign rem_after   = rem - {{(LW-4){1'b0}}, body_cnt};

    // Zero every DW at or beyond the emitted count.
    for (genvar g = 0; g < NDW; g++) begin : g_mask
        assign emit_mask[DATA_WIDTH-1-g*DW -: DW] = {DW{e_beat.cnt > 4'(g)}};
    end

    // Packet state machine: decides what (if anything) is emitted this cycle.
    always_comb begin
        state_nx = state;
        rem_nx   = rem;
        tail_nx  = tail;
        hdr4_nx  = hdr4;
        first_nx = first;
        emit     = 1'b0;
        e_beat   = '0;
        err_nx   = 1'b0;
        drop_inc = 1'b0;
        hdr_ld   = 1'b0;
        case (state)
            S_IDLE: begin
                if (acc) begin
                    if (!rx_sop) begin
                        err_nx = 1'b1;
                    end else if (!in_mwr) begin
                        drop_inc = 1'b1;
                        if (!rx_eop) state_nx = S_DROP;
                    end else begin
                        hdr_ld   = 1'b1;
                        hdr4_nx  = in_4dw;
                        tail_nx  = in_tail;
                        rem_nx   = in_len;
                        first_nx = 1'b1;
                        if (rx_eop) begin
                            // Whole TLP in one beat; an oversized length is truncated to what fits.
                            emit        = 1'b1;
                            e_beat.data = in_tail;
                            e_beat.sop  = 1'b1;
                            e_beat.eop  = 1'b1;
                            rem_nx      = '0;
                            if (in_len > in_tcnt) begin
                                err_nx     = 1'b1;
                                e_beat.cnt = in_tcnt[3:0];
                            end else begin
                                e_beat.cnt = in_len[3:0];
                            end
                        end else begin
                            state_nx = S_BODY;
                        end
                    end
                end
            end
            S_BODY: begin
                if (acc) begin
                    if (rx_sop) begin
                        // New packet started early: close the current one from the held
                        // tail and discard the intruder up to its eop.
                        err_nx      = 1'b1;
                        emit        = 1'b1;
                        e_beat.data = tail;
                        e_beat.cnt  = (rem > cur_tcnt) ? cur_tcnt[3:0] : rem[3:0];
                        e_beat.sop  = first;
                        e_beat.eop  = 1'b1;
                        rem_nx      = '0;
                        // A single-beat intruder is already complete; don't swallow the next TLP.
                        state_nx    = rx_eop ? S_IDLE : S_DROP;
                    end else begin
                        emit        = 1'b1;
                        e_beat.data = body_data;
                        e_beat.cnt  = body_cnt;
                        e_beat.sop  = first;
                        rem_nx      = rem_after;
                        tail_nx     = cur_tail_nx;
                        if (rx_eop) begin
                            if (rem_after == '0) begin
                                e_beat.eop = 1'b1;
                                state_nx   = S_IDLE;
                            end else if (rem_after > cur_tcnt) begin
                                // Packet ended short of its length field.
                                e_beat.eop = 1'b1;
                                err_nx     = 1'b1;
                                state_nx   = S_IDLE;
                            end else begin
                                state_nx   = S_FLUSH;
                            end
                        end else if (rem_after == '0) begin
                            // Length satisfied but the packet keeps going: drop the excess.
                            e_beat.eop = 1'b1;
                            err_nx     = 1'b1;
                            state_nx   = S_DROP;
                        end
                    end
                end
            end
            S_FLUSH: begin
                if (out_free) begin
                    emit        = 1'b1;
                    e_beat.data = tail;
                    e_beat.cnt  = rem[3:0];
                    e_beat.sop  = first;
                    e_beat.eop  = 1'b1;
                    rem_nx      = '0;
                    state_nx    = S_IDLE;
                end
            end
            S_DROP: begin
                if (acc && rx_eop) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
        if (emit) first_nx = 1'b0;
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            rem   <= '0;
            tail  <= '0;
            hdr4  <= 1'b0;
            first <= 1'b0;
            run   <= 1'b0;
        end else begin
            state <= state_nx;
            rem   <= rem_nx;
            tail  <= tail_nx;
            hdr4  <= hdr4_nx;
            first <= first_nx;
            run   <= 1'b1;
        end
    end

    // Output register: loads only when free, so a stalled beat holds steady.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tlp_valid  <= 1'b0;
            tlp_data   <= '0;
            tlp_dw_cnt <= '0;
            tlp_sop    <= 1'b0;
            tlp_eop    <= 1'b0;
        end else if (emit) begin
            tlp_valid  <= 1'b1;
            tlp_data   <= e_beat.data & emit_mask;
            tlp_dw_cnt <= e_beat.cnt;
            tlp_sop    <= e_beat.sop;
            tlp_eop    <= e_beat.eop;
        end else if (tlp_ready) begin
            tlp_valid  <= 1'b0;
        end
    end

    // Header capture, error pulse and saturating drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tlp_hdr  <= '0;
            rx_err   <= 1'b0;
            drop_cnt <= '0;
        end else begin
            rx_err <= err_nx;
            if (hdr_ld) tlp_hdr <= in_hdr;
            if (drop_inc && (drop_cnt != {CNT_WIDTH{1'b1}})) drop_cnt <= drop_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_tlp_rx_align.sv
// tb_tlp_rx_align: directed table of TLPs with hand-derived expected output
// beats, plus hand-written sequences for early sop, stray beats and reset.
module tb_tlp_rx_align;
    logic         clk, rst_n;
    logic [255:0] rx_data;
    logic         rx_sop, rx_eop, rx_valid, rx_ready;
    logic [127:0] tlp_hdr;
    logic [255:0] tlp_data;
    logic [3:0]   tlp_dw_cnt;
    logic         tlp_sop, tlp_eop, tlp_valid, tlp_ready;
    logic         rx_err;
    logic [15:0]  drop_cnt;

    tlp_rx_align dut (
        .clk(clk), .rst_n(rst_n),
        .rx_data(rx_data), .rx_sop(rx_sop), .rx_eop(rx_eop), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tlp_hdr(tlp_hdr), .tlp_data(tlp_data), .tlp_dw_cnt(tlp_dw_cnt),
        .tlp_sop(tlp_sop), .tlp_eop(tlp_eop), .tlp_valid(tlp_valid), .tlp_ready(tlp_ready),
        .rx_err(rx_err), .drop_cnt(drop_cnt)
    );

    // One TLP stimulus record and the output it must produce.
    typedef struct packed {
        bit            h4;
        bit [2:0]      fmt;
        bit [4:0]      typ;
        int            len;
        int            nbeats;
        int            base;
        bit [1:0]      trdy;   // 0: ready=1, 1: toggle, 2: ready=0
        int            nout;
        bit [0:3][3:0] cnt;
        int            err;
        int            drop;
        int            low;    // rx_ready low cycles, -1 = not checked
    } vec_t;

    typedef struct {
        logic [255:0] data;
        logic [127:0] hdr;
        logic [3:0]   cnt;
        logic         sop;
        logic         eop;
    } obeat_t;

    obeat_t oq[$];
    int     checks = 0, errors = 0;
    int     err_seen = 0, low_cnt = 0, exp_drop = 0;
    int     tready_mode = 0;
    bit     mon_win = 0;
    vec_t   vecs[14];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Downstream ready pattern, changed just after each rising edge.
    initial begin
        tlp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (tready_mode)
                1:       tlp_ready = ~tlp_ready;
                2:       tlp_ready = 1'b0;
                default: tlp_ready = 1'b1;
            endcase
        end
    end

    // Output monitor: collects transfers, counts error pulses and ready-low cycles,
    // and checks that a stalled beat does not change.
    initial begin
        obeat_t held;
        bit     stalled;
        stalled = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 1'b0;
            end else begin
                if (stalled && tlp_valid) begin
                    chk("stall_data", tlp_data, held.data);
                    chk("stall_ctl", 256'({tlp_dw_cnt, tlp_sop, tlp_eop}), 256'({held.cnt, held.sop, held.eop}));
                end
                if (tlp_valid && tlp_ready) oq.push_back('{tlp_data, tlp_hdr, tlp_dw_cnt, tlp_sop, tlp_eop});
                if (rx_err) err_seen++;
                if (mon_win && !rx_ready) low_cnt++;
                stalled = tlp_valid && !tlp_ready;
                held    = '{tlp_data, tlp_hdr, tlp_dw_cnt, tlp_sop, tlp_eop};
            end
        end
    end

    function automatic vec_t mk(bit h4, bit [2:0] fmt, bit [4:0] typ, int len, int nb, int base,
                                bit [1:0] trdy, int nout, bit [0:3][3:0] cnt, int err, int drop, int low);
        vec_t v;
        v.h4 = h4; v.fmt = fmt; v.typ = typ; v.len = len; v.nbeats = nb; v.base = base;
        v.trdy = trdy; v.nout = nout; v.cnt = cnt; v.err = err; v.drop = drop; v.low = low;
        return v;
    endfunction

    function automatic logic [31:0] hdr_dw(vec_t v, int i);
        case (i)
            0:       return {v.fmt, v.typ, 14'h0, 10'(v.len)};
            1:       return 32'h1111_0000 + 32'(v.base);
            2:       return 32'h2222_2222;
            default: return 32'h3333_3333;
        endcase
    endfunction

    function automatic logic [127:0] exp_hdr(vec_t v);
        return {hdr_dw(v, 0), hdr_dw(v, 1), hdr_dw(v, 2), v.h4 ? hdr_dw(v, 3) : 32'h0};
    endfunction

    // Beat b of the raw stream: header DWs, then payload base+k, then zero padding.
    function automatic logic [255:0] build_beat(vec_t v, int b);
        logic [255:0] r;
        logic [31:0]  d;
        int hh, ll, i;
        r  = '0;
        hh = v.h4 ? 4 : 3;
        ll = (v.len == 0) ? 1024 : v.len;
        for (int k = 0; k < 8; k++) begin
            i = b * 8 + k;
            if (i < hh)           d = hdr_dw(v, i);
            else if (i - hh < ll) d = 32'(v.base + i - hh);
            else                  d = 32'h0;
            r[255-32*k -: 32] = d;
        end
        return r;
    endfunction

    task automatic drive_beat(input logic [255:0] d, input logic s, input logic e);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        rx_data = d; rx_sop = s; rx_eop = e; rx_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (rx_ready) done = 1'b1;
            @(posedge clk);
            #1;
            n++;
            if (!done && n > 200) begin
                checks++;
                errors++;
                $display("FAIL rx_ready_timeout: got no accept after %0d cycles, required accept", n);
                done = 1'b1;
            end
        end
        rx_valid = 1'b0;
        rx_sop = 1'b0;
        rx_eop = 1'b0;
    endtask

    task automatic begin_pkt(input int mode);
        tready_mode = mode;
        oq.delete();
        err_seen = 0;
        low_cnt = 0;
        mon_win = 1'b1;
    endtask

    task automatic end_pkt();
        repeat (12) @(posedge clk);
        #1;
        mon_win = 1'b0;
        tready_mode = 0;
        @(posedge clk);
        #1;
    endtask

    // Output stream must be the payload in order, chunked per the expected counts.
    task automatic check_vec(input string nm, input vec_t v);
        logic [255:0] ed;
        int off;
        off = 0;
        chk({nm, "_nbeats"}, 256'(oq.size()), 256'(v.nout));
        for (int j = 0; j < v.nout && j < oq.size(); j++) begin
            ed = '0;
            for (int k = 0; k < 8; k++)
                if (k < int'(v.cnt[j])) ed[255-32*k -: 32] = 32'(v.base + off + k);
            chk($sformatf("%s_b%0d_cnt", nm, j), 256'(oq[j].cnt), 256'(v.cnt[j]));
            chk($sformatf("%s_b%0d_sopeop", nm, j), 256'({oq[j].sop, oq[j].eop}),
                256'({j == 0, j == v.nout - 1}));
            chk($sformatf("%s_b%0d_data", nm, j), oq[j].data, ed);
            chk($sformatf("%s_b%0d_hdr", nm, j), 256'(oq[j].hdr), 256'(exp_hdr(v)));
            off += int'(v.cnt[j]);
        end
        chk({nm, "_err"}, 256'(err_seen), 256'(v.err));
        if (v.low >= 0) chk({nm, "_rdy_low"}, 256'(low_cnt), 256'(v.low));
        exp_drop += v.drop;
        chk({nm, "_drop"}, 256'(drop_cnt), 256'(exp_drop));
    endtask

    task automatic run_vec(input string nm, input vec_t v);
        begin_pkt(v.trdy);
        for (int b = 0; b < v.nbeats; b++)
            drive_beat(build_beat(v, b), b == 0, b == v.nbeats - 1);
        end_pkt();
        check_vec(nm, v);
    endtask

    initial begin
        vec_t v;
        //             h4 fmt     typ       len nb base   trdy nout cnt                     err drop low
        vecs[0]  = mk(1, 3'b011, 5'b00000, 4,  1, 'hA0,  0,   1,   {4'd4,4'd0,4'd0,4'd0}, 0,  0,   0);
        vecs[1]  = mk(0, 3'b010, 5'b00000, 16, 3, 'h100, 0,   2,   {4'd8,4'd8,4'd0,4'd0}, 0,  0,   0);
        vecs[2]  = mk(1, 3'b011, 5'b00000, 12, 2, 'h200, 0,   2,   {4'd8,4'd4,4'd0,4'd0}, 0,  0,   1);
        vecs[3]  = mk(0, 3'b000, 5'b00000, 1,  2, 'h300, 0,   0,   {4'd0,4'd0,4'd0,4'd0}, 0,  1,   0);
        vecs[4]  = mk(0, 3'b010, 5'b00100, 1,  2, 'h400, 0,   0,   {4'd0,4'd0,4'd0,4'd0}, 0,  1,   0);
        vecs[5]  = mk(0, 3'b010, 5'b00000, 8,  2, 'h500, 0,   1,   {4'd8,4'd0,4'd0,4'd0}, 0,  0,   0);
        vecs[6]  = mk(0, 3'b010, 5'b00000, 32, 5, 'h600, 1,   4,   {4'd8,4'd8,4'd8,4'd8}, 0,  0,  -1);
        vecs[7]  = mk(1, 3'b011, 5'b00000, 16, 2, 'h700, 0,   1,   {4'd8,4'd0,4'd0,4'd0}, 1,  0,   0);
        vecs[8]  = mk(0, 3'b010, 5'b00000, 13, 2, 'h800, 0,   2,   {4'd8,4'd5,4'd0,4'd0}, 0,  0,   1);
        vecs[9]  = mk(1, 3'b011, 5'b00000, 6,  1, 'h900, 0,   1,   {4'd4,4'd0,4'd0,4'd0}, 1,  0,   0);
        vecs[10] = mk(0, 3'b010, 5'b00000, 5,  1, 'hA00, 0,   1,   {4'd5,4'd0,4'd0,4'd0}, 0,  0,   0);
        vecs[11] = mk(0, 3'b010, 5'b00000, 3,  3, 'hB00, 0,   1,   {4'd3,4'd0,4'd0,4'd0}, 1,  0,   0);
        vecs[12] = mk(0, 3'b010, 5'b00000, 0,  1, 'hC00, 0,   1,   {4'd5,4'd0,4'd0,4'd0}, 1,  0,   0);
        vecs[13] = mk(1, 3'b001, 5'b00000, 2,  1, 'hD00, 0,   0,   {4'd0,4'd0,4'd0,4'd0}, 0,  1,   0);

        rst_n = 1'b0; rx_data = '0; rx_sop = 1'b0; rx_eop = 1'b0; rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctl", 256'({rx_ready, tlp_valid, tlp_sop, tlp_eop, tlp_dw_cnt, rx_err}), 256'(0));
        chk("reset_data", tlp_data, 256'(0));
        chk("reset_hdr_drop", 256'({tlp_hdr, drop_cnt}), 256'(0));
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("ready_after_reset", 256'(rx_ready), 256'(1));

        for (int i = 0; i < 14; i++) run_vec($sformatf("v%0d", i), vecs[i]);

        // Stray beat without sop while idle.
        begin_pkt(0);
        drive_beat({8{32'hDEAD_BEEF}}, 1'b0, 1'b1);
        end_pkt();
        check_vec("nosop", mk(0, 3'b010, 5'b00000, 1, 1, 0, 0, 0, {4'd0,4'd0,4'd0,4'd0}, 1, 0, 0));

        // sop arrives mid-packet: current packet closed from its held tail, intruder dropped.
        v = mk(0, 3'b010, 5'b00000, 16, 3, 'hE00, 0, 1, {4'd5,4'd0,4'd0,4'd0}, 1, 0, 0);
        begin_pkt(0);
        drive_beat(build_beat(v, 0), 1'b1, 1'b0);
        drive_beat(build_beat(vecs[3], 0), 1'b1, 1'b0);
        drive_beat(build_beat(vecs[3], 1), 1'b0, 1'b1);
        end_pkt();
        check_vec("early_sop", v);
        run_vec("after_early_sop", vecs[5]);

        // Reset while a packet is in flight and an output beat is stalled.
        v = mk(0, 3'b010, 5'b00000, 32, 5, 'hF00, 2, 0, {4'd0,4'd0,4'd0,4'd0}, 0, 0, 0);
        tready_mode = 2;
        @(posedge clk);
        #1;
        drive_beat(build_beat(v, 0), 1'b1, 1'b0);
        drive_beat(build_beat(v, 1), 1'b0, 1'b0);
        @(negedge clk);
        chk("pre_rst_valid", 256'(tlp_valid), 256'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ctl", 256'({rx_ready, tlp_valid, tlp_sop, tlp_eop, tlp_dw_cnt, rx_err}), 256'(0));
        chk("mid_rst_data", tlp_data, 256'(0));
        chk("mid_rst_hdr_drop", 256'({tlp_hdr, drop_cnt}), 256'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_drop = 0;
        tready_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        run_vec("post_rst", vecs[2]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tlp_rx_align.md
Name: tlp_rx_align

Overview:
- Upstream feeder for the TLP-to-AXI write converter.
- Takes the raw 256-bit PCIe RX stream and extracts the 3DW/4DW header. Only memory-write TLPs (fmt[1]=1, type=5'b00000) are forwarded; all other TLPs are dropped.
- Re-aligns the payload so payload DW0 sits at tlp_data[255:224]. Presents the header held stable for the whole packet, plus per-beat sop/eop, valid-DW count and valid/ready.

Parameters:
- DW, 32, double-word width.
- DATA_WIDTH, 256, stream width (8 DW); fixed.
- HDR_WIDTH, 128, header output width (4 DW).
- CNT_WIDTH, 16, width of the saturating drop counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- rx_data  in  256  raw beat, DW0 at [255:224], DWn at [255-32n -: 32]
- rx_sop  in  1  first beat of TLP
- rx_eop  in  1  last beat of TLP
- rx_valid  in  1  beat valid
- rx_ready  out  1  beat accepted when rx_valid & rx_ready
- tlp_hdr  out  128  header, DW0 at [127:96]; for a 3DW header, [31:0]=0
- tlp_data  out  256  aligned payload; DWs beyond the valid count are zero
- tlp_dw_cnt  out  4  valid DWs in beat (1..8)
- tlp_sop  out  1  first payload beat
- tlp_eop  out  1  last payload beat
- tlp_valid  out  1  output beat valid
- tlp_ready  in  1  downstream ready
- rx_err  out  1  one-cycle pulse on framing/length error
- drop_cnt  out  16  saturating count of dropped TLPs

Interface (already decided):
- One clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
- Reset: all outputs 0, including rx_ready, tlp_valid, tlp_hdr, tlp_data, drop_cnt. State returns to S_IDLE. A reset mid-packet discards the partial packet without error.
- Header size H: 4 if rx_data[253] (fmt[0]) else 3.
- Payload length L: rx_data[233:224]; a value of 0 means 1024.
- Expected input beats: ceil((H+L)/8). Output beats: ceil(L/8).
- Output stage: one register. rx_ready = (!tlp_valid | tlp_ready) & (state != S_FLUSH). An output beat is held stable until tlp_valid & tlp_ready.
- rem register (11 bits): payload DWs not yet emitted. tail register: DWs H..7 of the last accepted beat.
- S_IDLE:
  - Accepted beat without rx_sop: rx_err pulse, beat discarded.
  - Accepted sop beat that is not a memory write: drop_cnt+1 (saturate at 0xFFFF). Go to S_DROP unless rx_eop, else stay.
  - Accepted sop beat that is a memory write: capture tlp_hdr; rem=L; store tail.
    - If rx_eop: emit tail as one beat (sop=eop=1, dw_cnt=L). Requires L<=8-H, otherwise rx_err and the beat is still emitted truncated. Stay in S_IDLE.
    - Else go to S_BODY.
- S_BODY, each accepted beat:
  - Emit {tail(8-H DW), beat DW0..H-1}. dw_cnt=min(rem,8). rem-=dw_cnt. sop=1 on the first emitted beat. Store new tail.
  - rx_eop with rem(after)>0: go to S_FLUSH.
  - rx_eop with rem==0: eop=1, go to S_IDLE.
  - rem reaches 0 without rx_eop: eop=1, go to S_DROP to discard excess beats, rx_err pulse.
  - rx_eop while rem(after) > 8-H (short packet): force eop=1 on that beat, rx_err, go to S_IDLE.
  - rx_sop in S_BODY: rx_err; the current packet is closed by forcing eop on that beat; the new beat is discarded; go to S_DROP.
- S_FLUSH: rx_ready=0. When the output register is free, emit tail with dw_cnt=rem, eop=1; rem=0; go to S_IDLE.
- S_DROP: accept beats and discard until an accepted rx_eop, then go to S_IDLE.
- Latency: an output beat is registered one cycle after the accepting input beat. Sustained throughput is 1 beat/cycle with tlp_ready=1, except one bubble for S_FLUSH.
- tlp_hdr changes only on an accepted memory-write sop beat while the output register is free.

Test Plan:
- 4DW MWr, L=4, single beat rx_sop=rx_eop=1, payload 0xA0..0xA3 in DW4..7 -> one beat: sop=eop=1, dw_cnt=4, tlp_data[255:128]=A0..A3, [127:0]=0, tlp_hdr=DW0..3.
- 3DW MWr, L=16, three input beats -> two output beats with dw_cnt 8,8; second beat has eop; no flush; tlp_hdr[31:0]=0.
- 4DW MWr, L=12, two input beats -> output beats dw_cnt 8 and 4 via S_FLUSH; rx_ready low exactly one cycle.
- MRd (fmt=000) then CfgWr (type=00100), each 2 beats -> nothing output; drop_cnt=2; following MWr forwarded correctly.
- tlp_ready toggled 1-0-1 every cycle during 3DW MWr, L=32 -> all 4 output beats in order, data stable while stalled, no loss or duplication.
- 4DW MWr, L=16 but rx_eop on 2nd beat -> rx_err pulse, eop forced on last emitted beat. Separately, assert rst_n low mid-packet -> all outputs 0 and the next packet is clean.
